// File: rtl/spi_slave_core.sv
// ============================================================================
// Module : spi_slave_core
// SPI responder on the system clock: pin synchronizers, all CPOL/CPHA modes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_slave_core #(
   parameter int                DATA_W      = 8,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] DUMMY       = 8'hFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              tx_underrun,
   output logic              frame_err
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_d, cs_d;
   logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic                   lead_edge, trail_edge;
   logic                   start, stop, in_frame;
   logic                   do_sample, do_shift, word_done, reload;

   logic [1:0]             mode_r;
   logic [DATA_W-1:0]      shift_reg, rx_shift, rx_next, load_word;
   logic [CW-1:0]          bit_cnt;
   logic                   first_shift;
   logic                   hold_full;
   logic [DATA_W-1:0]      hold_data;

   // cs_n chain resets high so reset release never looks like a select
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign cs_rise   = cs_s & ~cs_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      stop     = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               start    = 1'b1;
               state_nx = ACTIVE;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               stop     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy     = (state == ACTIVE);
   assign miso_oe  = busy;
   assign tx_ready = ~hold_full;

   assign lead_edge  = mode_r[1] ? sclk_fall : sclk_rise;
   assign trail_edge = mode_r[1] ? sclk_rise : sclk_fall;
   assign in_frame   = busy & ~stop;
   assign do_sample  = in_frame & (mode_r[0] ? trail_edge : lead_edge);
   assign do_shift   = in_frame & (mode_r[0] ? lead_edge : trail_edge);
   assign word_done  = do_sample & (bit_cnt == CW'(DATA_W - 1));
   assign reload     = start | word_done;
   assign load_word  = hold_full ? hold_data : DUMMY;
   assign rx_next    = {rx_shift[DATA_W-2:0], mosi_s};

   // A reload arms first_shift so the next shift edge presents the new MSB
   // instead of discarding it; this covers back-to-back frames and CPHA=1 starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_r      <= 2'b00;
         shift_reg   <= '0;
         rx_shift    <= '0;
         rx_data     <= '0;
         bit_cnt     <= '0;
         first_shift <= 1'b0;
         miso        <= 1'b0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;

         if (reload) begin
            shift_reg   <= load_word;
            tx_underrun <= ~hold_full;
         end

         if (start) begin
            mode_r  <= mode;
            bit_cnt <= '0;
            if (mode[0]) begin
               first_shift <= 1'b1;
            end else begin
               first_shift <= 1'b0;
               miso        <= load_word[DATA_W-1];
            end
         end

         if (do_sample) begin
            rx_shift <= rx_next;
            if (word_done) begin
               bit_cnt     <= '0;
               rx_data     <= rx_next;
               rx_valid    <= 1'b1;
               first_shift <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
            end
         end

         if (do_shift) begin
            if (first_shift) begin
               first_shift <= 1'b0;
               miso        <= shift_reg[DATA_W-1];
            end else begin
               shift_reg <= shift_reg << 1;
               miso      <= shift_reg[DATA_W-2];
            end
         end

         if (stop) begin
            miso    <= 1'b0;
            bit_cnt <= '0;
            if (bit_cnt != '0) frame_err <= 1'b1;
         end
      end
   end

   // Writes only land while empty and consumption only happens while full,
   // so a same-cycle write into an empty register survives for the next frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else begin
         if (reload && hold_full) hold_full <= 1'b0;
         if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a bit-banged SPI master drives the pins.
`default_nettype none

module tb_spi_slave_core;

   localparam int HALF  = 6;
   localparam int SETUP = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode = 2'b00;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_err;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic [7:0] rx_data;

   always #5 clk = ~clk;

   spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2), .DUMMY(8'hFF)) dut (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode),
      .sclk       (sclk),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .busy       (busy),
      .tx_underrun(tx_underrun),
      .frame_err  (frame_err)
   );

   int         pass_cnt = 0;
   int         total    = 0;
   int         rxv_cnt  = 0;
   int         und_cnt  = 0;
   int         ferr_cnt = 0;
   logic [7:0] rx_log[$];

   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_cnt++;
         rx_log.push_back(rx_data);
      end
      if (tx_underrun) und_cnt++;
      if (frame_err)   ferr_cnt++;
   end

   typedef struct {
      logic [1:0] mode;
      logic       preload;
      logic [7:0] tx;
      logic [7:0] mo;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
      int         exp_und;
   } vec_t;

   vec_t vecs[6];

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic load(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      clks(1);
      tx_valid = 1'b0;
   endtask

   task automatic xfer(input logic [1:0] m, input logic [7:0] mo,
                       output logic [7:0] mi, input int nbits);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (!m[0]) begin
            mosi = mo[7-i];
            clks(HALF);
            mi[7-i] = miso;
            sclk = ~m[1];
            clks(HALF);
            sclk = m[1];
         end else begin
            sclk = ~m[1];
            mosi = mo[7-i];
            clks(HALF);
            mi[7-i] = miso;
            sclk = m[1];
            clks(HALF);
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      logic [7:0] mi;
      int u0, r0, f0;
      mode = v.mode;
      sclk = v.mode[1];
      clks(SETUP);
      if (v.preload) begin
         load(v.tx);
         chk({nm, "_tx_ready_low"}, tx_ready, 1'b0);
         load(~v.tx);
      end
      u0 = und_cnt; r0 = rxv_cnt; f0 = ferr_cnt;
      cs_n = 1'b0;
      clks(SETUP);
      chk({nm, "_underrun"}, und_cnt - u0, v.exp_und);
      chk({nm, "_busy_oe"}, {busy, miso_oe}, 2'b11);
      xfer(v.mode, v.mo, mi, 8);
      clks(SETUP);
      chk({nm, "_rx_pulses"}, rxv_cnt - r0, 1);
      chk({nm, "_rx_data"}, rx_data, v.exp_rx);
      chk({nm, "_miso_word"}, mi, v.exp_miso);
      cs_n = 1'b1;
      clks(SETUP);
      chk({nm, "_no_ferr"}, ferr_cnt - f0, 0);
      chk({nm, "_idle"}, {busy, miso_oe}, 2'b00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] mi1, mi2;
      int r0, f0, sz, waited;
      logic [15:0] pair;
      vec_t extra;

      vecs[0] = '{2'd0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
      vecs[1] = '{2'd1, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 0};
      vecs[2] = '{2'd2, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 0};
      vecs[3] = '{2'd3, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 0};
      vecs[4] = '{2'd0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 1};
      vecs[5] = '{2'd3, 1'b0, 8'h00, 8'h81, 8'hFF, 8'h81, 1};

      clks(5);
      chk("reset_outputs", {miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_err},
          7'b0010000);
      chk("reset_rx_data", rx_data, 8'h00);
      reset = 1'b0;
      clks(5);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // back-to-back frames with cs_n held low
      mode = 2'd0; sclk = 1'b0;
      clks(SETUP);
      load(8'h11);
      r0 = rxv_cnt;
      cs_n = 1'b0;
      clks(SETUP);
      waited = 0;
      while (!tx_ready && waited < 20) begin
         clks(1);
         waited++;
      end
      chk("b2b_tx_ready_rise", tx_ready, 1'b1);
      load(8'h22);
      xfer(2'd0, 8'hF0, mi1, 8);
      xfer(2'd0, 8'h0F, mi2, 8);
      clks(SETUP);
      chk("b2b_rx_pulses", rxv_cnt - r0, 2);
      sz = rx_log.size();
      pair = 16'h0000;
      if (sz >= 2) pair = {rx_log[sz-2], rx_log[sz-1]};
      chk("b2b_rx_words", pair, 16'hF00F);
      chk("b2b_miso_words", {mi1, mi2}, 16'h1122);
      cs_n = 1'b1;
      clks(SETUP);

      // partial frame of 5 bits, then a clean frame
      r0 = rxv_cnt; f0 = ferr_cnt;
      cs_n = 1'b0;
      clks(SETUP);
      xfer(2'd0, 8'hFF, mi1, 5);
      clks(HALF);
      cs_n = 1'b1;
      clks(SETUP);
      chk("partial_ferr", ferr_cnt - f0, 1);
      chk("partial_no_rx", rxv_cnt - r0, 0);
      extra = '{2'd0, 1'b1, 8'h3C, 8'h96, 8'h3C, 8'h96, 0};
      run_vec(extra, "after_partial");

      // reset in the middle of a frame
      mode = 2'd0; sclk = 1'b0;
      load(8'h5A);
      cs_n = 1'b0;
      clks(SETUP);
      xfer(2'd0, 8'hAA, mi1, 4);
      clks(2);
      r0 = rxv_cnt; f0 = ferr_cnt;
      reset = 1'b1;
      #1;
      chk("midreset_outputs", {miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_err},
          7'b0010000);
      chk("midreset_rx_data", rx_data, 8'h00);
      cs_n = 1'b1;
      sclk = 1'b0;
      clks(SETUP);
      reset = 1'b0;
      clks(SETUP);
      chk("midreset_no_pulses", {rxv_cnt - r0, ferr_cnt - f0}, 64'd0);
      chk("midreset_tx_ready", tx_ready, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

`default_nettype wire
